// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding,
// default memory depth and the byte counts of the header and of a data word.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int MEM_WORDS_DEF = 1024;
    localparam int HDR_BYTES     = 2;
    localparam int WORD_BYTES    = 4;

    localparam logic       HDR_LAST_IDX  = 1'(HDR_BYTES - 1);
    localparam logic [1:0] WORD_LAST_IDX = 2'(WORD_BYTES - 1);

    // Byte address of a 32-bit word index.
    function automatic logic [31:0] word_byte_addr(input logic [10:0] idx);
        return {19'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes little-endian into a 32-bit word; flags the byte that
// completes a word. The assembled word is held until the next shift.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [31:0] word_r;
    logic [1:0]  byte_idx_r;

    // Byte lane write and lane index; clear discards a partial word.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            word_r     <= 32'd0;
            byte_idx_r <= 2'd0;
        end else if (clr_i) begin
            word_r     <= 32'd0;
            byte_idx_r <= 2'd0;
        end else if (shift_i) begin
            word_r[{byte_idx_r, 3'b000} +: 8] <= byte_i;
            byte_idx_r                        <= byte_idx_r + 2'd1;
        end else begin
            word_r     <= word_r;
            byte_idx_r <= byte_idx_r;
        end
    end

    assign word_o      = word_r;
    assign word_done_o = shift_i && (byte_idx_r == WORD_LAST_IDX);

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the
// core in reset. Optional trailing XOR checksum: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [10:0] word_cnt_o
);

    localparam logic [15:0] MEM_WORDS_W = 16'(MEM_WORDS);

    state_e      state_r;
    state_e      state_nxt_s;
    logic        hdr_idx_r;
    logic [15:0] n_r;
    logic [10:0] word_cnt_r;
    logic [31:0] word_s;
    logic        word_done_s;

    logic        accept_s;
    logic        start_go_s;
    logic        shift_s;
    logic        hdr_acc_s;
    logic [15:0] n_full_s;
    logic        hdr_bad_s;
    logic        more_s;

    assign accept_s   = byte_valid_i && byte_ready_o;
    assign start_go_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                    (state_r == ST_ERR));
    assign shift_s    = accept_s && (state_r == ST_DATA);
    assign hdr_acc_s  = accept_s && (state_r == ST_HDR);
    assign n_full_s   = {byte_data_i, n_r[7:0]};
    assign hdr_bad_s  = (n_full_s == 16'd0) || (n_full_s > MEM_WORDS_W);
    assign more_s     = (({5'd0, word_cnt_r} + 16'd1) < n_r);
    assign word_cnt_o = word_cnt_r;

    word_assembler u_word_assembler (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clr_i       (start_go_s),
        .shift_i     (shift_s),
        .byte_i      (byte_data_i),
        .word_o      (word_s),
        .word_done_o (word_done_s)
    );

    // Header capture: low byte of N first, then high byte.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hdr_idx_r <= 1'b0;
            n_r       <= 16'd0;
        end else if (start_go_s) begin
            hdr_idx_r <= 1'b0;
            n_r       <= 16'd0;
        end else if (hdr_acc_s) begin
            if (hdr_idx_r == HDR_LAST_IDX) begin
                n_r[15:8] <= byte_data_i;
            end else begin
                n_r[7:0]  <= byte_data_i;
                hdr_idx_r <= HDR_LAST_IDX;
            end
        end else begin
            hdr_idx_r <= hdr_idx_r;
            n_r       <= n_r;
        end
    end

    // Word counter doubles as the write word index.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            word_cnt_r <= 11'd0;
        end else if (start_go_s) begin
            word_cnt_r <= 11'd0;
        end else if (state_r == ST_WRITE) begin
            word_cnt_r <= word_cnt_r + 11'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum_r;

    // Running XOR over payload bytes only (header excluded).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            csum_r <= 8'd0;
        end else if (start_go_s) begin
            csum_r <= 8'd0;
        end else if (shift_s) begin
            csum_r <= csum_r ^ byte_data_i;
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) state_nxt_s = ST_HDR;
                else         state_nxt_s = state_r;
            end
            ST_HDR: begin
                if (hdr_acc_s && (hdr_idx_r == HDR_LAST_IDX)) begin
                    if (hdr_bad_s) state_nxt_s = ST_ERR;
                    else           state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (word_done_s) state_nxt_s = ST_WRITE;
                else             state_nxt_s = ST_DATA;
            end
            ST_WRITE: begin
                if (more_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_nxt_s = ST_CHK;
`else
                    state_nxt_s = ST_DONE;
`endif
                end
            end
            ST_CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (accept_s) begin
                    if (byte_data_i == csum_r) state_nxt_s = ST_DONE;
                    else                       state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_CHK;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Moore output decode; the write port is zero outside WRITE.
    always_comb begin
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 32'd0;
        mem_wdata_o  = 32'd0;
        core_rst_o   = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        case (state_r)
            ST_HDR, ST_DATA, ST_CHK: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                core_rst_o   = 1'b1;
            end
            ST_WRITE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = word_byte_addr(word_cnt_r);
                mem_wdata_o = word_s;
                busy_o      = 1'b1;
                core_rst_o  = 1'b1;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            ST_ERR: begin
                err_o      = 1'b1;
                core_rst_o = 1'b1;
            end
            default: begin
                byte_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: a reference model turns each byte
// session into expected memory writes and final status; a monitor checks writes.
module tb_instr_loader;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [10:0] word_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    instr_loader #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Little-endian word k of the payload, by arithmetic on the byte list.
    function automatic logic [31:0] word_of(input int k);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++) w = w + (32'(data_q[4*k+j]) << (8*j));
        return w;
    endfunction

    task automatic fill_random(input int nbytes);
        data_q.delete();
        for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Monitor: every write must match the next expected write, and be stalling input.
    always @(negedge clk) begin
        if (mem_we_o) begin
            check("ready_low_in_write", {63'd0, byte_ready_o}, 64'd0);
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                check("write_addr", {32'd0, mem_addr_o}, {32'd0, exp_addr_q.pop_front()});
                check("write_data", {32'd0, mem_wdata_o}, {32'd0, exp_data_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (byte_ready_o) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout actual=ready low required=accepted byte %0h", b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("status_after_start", {60'd0, busy_o, core_rst_o, done_o, err_o}, 64'hC);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {51'd0, byte_ready_o, mem_we_o, core_rst_o, busy_o, done_o, err_o,
                     word_cnt_o, 2'b00}, 64'd0);
        check({name, "_bus"}, {mem_addr_o, mem_wdata_o}, 64'd0);
    endtask

    // One load session over data_q; the model decides writes and final status.
    task automatic run_load(input logic [7:0] h0, input logic [7:0] h1, input bit gaps,
                            input bit bad);
        int   n;
        bit   ok;
        bit   exp_done;
        int   k;
        logic [7:0] x;
        n  = int'(h1) * 256 + int'(h0);
        ok = (n != 0) && (n <= MEM_WORDS);
        x  = 8'd0;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(32'(4 * i));
                exp_data_q.push_back(word_of(i));
            end
            for (int i = 0; i < 4 * n; i++) x = x ^ data_q[i];
        end
        pulse_start();
        send_byte(h0, gaps);
        send_byte(h1, gaps);
        if (ok) begin
            for (int i = 0; i < 4 * n; i++) send_byte(data_q[i], gaps);
`ifdef INSTR_LOADER_CHECKSUM_EN
            send_byte(x ^ {7'd0, bad}, gaps);
`endif
        end
        byte_valid = 1'b0;
        exp_done = ok && !bad;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (done_o || err_o) break;
            k++;
        end
        if (k >= 20) begin
            checks++;
            failures++;
            $display("FAIL session_end_timeout actual=busy required=done or err");
        end
        check("final_status", {60'd0, done_o, err_o, core_rst_o, busy_o},
              {60'd0, exp_done, !exp_done, !exp_done, 1'b0});
        check("word_cnt", {53'd0, word_cnt_o}, ok ? 64'(n) : 64'd0);
        check("pending_writes", 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Two-word program, valid held high throughout.
        data_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        run_load(8'h02, 8'h00, 1'b0, 1'b0);

        // Illegal headers: N = 0 and N = MEM_WORDS + 1.
        data_q.delete();
        run_load(8'h00, 8'h00, 1'b0, 1'b0);
        run_load(8'h01, 8'h04, 1'b0, 1'b0);

        // Random sizes, data and valid gaps.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            fill_random(4 * n);
`ifdef INSTR_LOADER_CHECKSUM_EN
            run_load(8'(n), 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            run_load(8'(n), 8'h00, 1'($urandom_range(0, 1)), 1'b0);
`endif
        end

        // Reset after six payload bytes: only word 0 is written.
        fill_random(8);
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(word_of(0));
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(data_q[i], 1'b0);
        byte_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("mid_session_reset");
        check("writes_before_reset", 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        fill_random(12);
        run_load(8'h03, 8'h00, 1'b1, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(8'h01, 8'h00, 1'b0, 1'b0);
        run_load(8'h01, 8'h00, 1'b0, 1'b1);
`endif

        // Full-depth load: last write lands at 0xFFC.
        fill_random(4 * MEM_WORDS);
        run_load(8'h00, 8'h04, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
